// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: arms the random delay, lights "go", times the
// press in milliseconds, flags false starts and timeouts, and tracks the best time.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ARM    | one-cycle arm pulse to the delay generator
// WAIT   | random delay running; a press here is a false start
// GO     | LED lit, timing the press
// RESULT | last time held (valid press or timeout)
// FOUL   | false start; waiting for start once the delay has drained
module reaction_ctrl #(
  parameter int CYC_PER_MS = 50_000,
  parameter int TIMEOUT_MS = 9_999
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iPRESS,
  input  logic        iDLY_DONE,
  output logic        oDLY_EN,
  output logic        oLED,
  output logic [13:0] oTIME,
  output logic [13:0] oBEST,
  output logic        oVALID,
  output logic        oFOUL,
  output logic        oTIMEOUT
);

  localparam int PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CYC_PER_MS - 1);
  localparam logic [13:0] MS_MAX = 14'(TIMEOUT_MS);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, GO, RESULT, FOUL} state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [13:0]   ms;
  logic [13:0]   ms_nxt;
  logic          dly_busy;
  logic          wrap;

  assign wrap   = (pre == PRE_LAST);
  assign ms_nxt = (ms == MS_MAX) ? ms : ms + 14'd1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      pre      <= '0;
      ms       <= '0;
      dly_busy <= 1'b0;
      oDLY_EN  <= 1'b0;
      oLED     <= 1'b0;
      oTIME    <= '0;
      oBEST    <= '0;
      oVALID   <= 1'b0;
      oFOUL    <= 1'b0;
      oTIMEOUT <= 1'b0;
    end else begin
      oDLY_EN <= 1'b0;
      oVALID  <= 1'b0;

      // A done pulse always wins, so a stale done seen after a foul drains the busy flag.
      if (iDLY_DONE)
        dly_busy <= 1'b0;
      else if (oDLY_EN)
        dly_busy <= 1'b1;

      case (state)
        IDLE, RESULT, FOUL: begin
          if (iSTART && !dly_busy) begin
            state    <= ARM;
            oDLY_EN  <= 1'b1;
            oFOUL    <= 1'b0;
            oTIMEOUT <= 1'b0;
          end
        end
        ARM: begin
          if (iPRESS) begin
            state <= FOUL;
            oFOUL <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (iPRESS) begin
            state <= FOUL;
            oFOUL <= 1'b1;
          end else if (iDLY_DONE) begin
            state <= GO;
            oLED  <= 1'b1;
            pre   <= '0;
            ms    <= '0;
          end
        end
        GO: begin
          if (iPRESS) begin
            state  <= RESULT;
            oLED   <= 1'b0;
            oTIME  <= ms;
            oVALID <= 1'b1;
            // A first-millisecond press records 0 but never becomes the best.
            if (ms != 14'd0 && (oBEST == 14'd0 || ms < oBEST))
              oBEST <= ms;
          end else begin
            pre <= wrap ? '0 : pre + 1'b1;
            if (wrap)
              ms <= ms_nxt;
            if (wrap && ms_nxt == MS_MAX) begin
              state    <= RESULT;
              oLED     <= 1'b0;
              oTIME    <= MS_MAX;
              oTIMEOUT <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: two instances (long and short timeout) driven by shared
// button stimulus, each with its own emulated delay generator, checked against a game model.
module tb_reaction_ctrl;

  localparam int CYC  = 10;
  localparam int TO_A = 9999;
  localparam int TO_B = 4;
  localparam int S_IDLE = 0, S_ARM = 1, S_WAIT = 2, S_GO = 3, S_RES = 4, S_FOUL = 5;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic iSTART = 1'b0;
  logic iPRESS = 1'b0;
  logic [1:0] done = 2'b00;
  logic [1:0] en_o, led_o, valid_o, foul_o, tout_o;
  logic [13:0] time_o [2];
  logic [13:0] best_o [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  // model of the game per instance
  int ph [2];
  int gc [2];
  int m_time [2];
  int m_best [2];
  bit busy [2];
  bit m_en [2];
  bit m_led [2];
  bit m_valid [2];
  bit m_foul [2];
  bit m_tout [2];
  int to_ms [2] = '{TO_A, TO_B};

  // delay generator emulation
  int gcnt [2] = '{0, 0};
  int dly_len = 20;

  always #5 iCLK = ~iCLK;

  reaction_ctrl #(.CYC_PER_MS(CYC), .TIMEOUT_MS(TO_A)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iPRESS(iPRESS), .iDLY_DONE(done[0]),
    .oDLY_EN(en_o[0]), .oLED(led_o[0]), .oTIME(time_o[0]), .oBEST(best_o[0]),
    .oVALID(valid_o[0]), .oFOUL(foul_o[0]), .oTIMEOUT(tout_o[0])
  );

  reaction_ctrl #(.CYC_PER_MS(CYC), .TIMEOUT_MS(TO_B)) dut_b (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iPRESS(iPRESS), .iDLY_DONE(done[1]),
    .oDLY_EN(en_o[1]), .oLED(led_o[1]), .oTIME(time_o[1]), .oBEST(best_o[1]),
    .oVALID(valid_o[1]), .oFOUL(foul_o[1]), .oTIMEOUT(tout_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (iRST) begin
        ph[i] = S_IDLE; busy[i] = 0; gc[i] = 0;
        m_en[i] = 0; m_led[i] = 0; m_valid[i] = 0; m_foul[i] = 0; m_tout[i] = 0;
        m_time[i] = 0; m_best[i] = 0;
      end else begin
        bit nb;
        int ms;
        nb = busy[i];
        if (m_en[i]) nb = 1;
        if (done[i]) nb = 0;
        m_en[i] = 0;
        m_valid[i] = 0;
        case (ph[i])
          S_IDLE, S_RES, S_FOUL:
            if (iSTART && !busy[i]) begin
              ph[i] = S_ARM; m_en[i] = 1; m_foul[i] = 0; m_tout[i] = 0;
            end
          S_ARM:
            if (iPRESS) begin ph[i] = S_FOUL; m_foul[i] = 1; end
            else ph[i] = S_WAIT;
          S_WAIT:
            if (iPRESS) begin ph[i] = S_FOUL; m_foul[i] = 1; end
            else if (done[i]) begin ph[i] = S_GO; gc[i] = 0; m_led[i] = 1; end
          S_GO: begin
            ms = gc[i] / CYC;
            if (iPRESS) begin
              ph[i] = S_RES; m_led[i] = 0; m_time[i] = ms; m_valid[i] = 1;
              if (ms != 0 && (m_best[i] == 0 || ms < m_best[i])) m_best[i] = ms;
            end else if ((gc[i] + 1) % CYC == 0 && (gc[i] + 1) / CYC >= to_ms[i]) begin
              ph[i] = S_RES; m_led[i] = 0; m_time[i] = to_ms[i]; m_tout[i] = 1;
            end else begin
              gc[i]++;
            end
          end
          default: ;
        endcase
        busy[i] = nb;
      end
    end
  endtask

  // One clock: model consumes this cycle's inputs, then the next cycle's inputs are set up.
  task automatic tick();
    @(posedge iCLK);
    model_step();
    #1;
    iSTART = 0;
    iPRESS = 0;
    for (int i = 0; i < 2; i++) begin
      done[i] = 0;
      if (iRST) gcnt[i] = 0;
      else if (en_o[i] === 1'b1) gcnt[i] = dly_len;
      else if (gcnt[i] > 0) begin
        gcnt[i]--;
        if (gcnt[i] == 0) done[i] = 1;
      end
    end
  endtask

  task automatic wait_led(input int i);
    int k;
    for (k = 0; k < 100; k++) begin
      tick();
      if (led_o[i] === 1'b1) break;
    end
    chk("led_rise_in_budget", (k < 100) ? 1 : 0, 1);
  endtask

  task automatic wait_done(input int i);
    int k;
    for (k = 0; k < 60; k++) begin
      tick();
      if (done[i] === 1'b1) break;
    end
    chk("dly_done_in_budget", (k < 60) ? 1 : 0, 1);
  endtask

  // start a round and press n cycles after the LED rises
  task automatic play(input int n);
    iSTART = 1;
    tick();
    chk("arm_pulse", en_o[0], 1);
    tick();
    chk("arm_single_cycle", en_o[0], 0);
    wait_led(0);
    repeat (n) tick();
    iPRESS = 1;
    tick();
  endtask

  always @(negedge iCLK) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_dly_en[%0d]", i), en_o[i], m_en[i]);
        chk($sformatf("model_led[%0d]", i), led_o[i], m_led[i]);
        chk($sformatf("model_valid[%0d]", i), valid_o[i], m_valid[i]);
        chk($sformatf("model_foul[%0d]", i), foul_o[i], m_foul[i]);
        chk($sformatf("model_timeout[%0d]", i), tout_o[i], m_tout[i]);
        chk($sformatf("model_time[%0d]", i), time_o[i], m_time[i]);
        chk($sformatf("model_best[%0d]", i), best_o[i], m_best[i]);
      end
    end
  end

  initial begin
    tick();
    chk_on = 1;
    tick();
    chk("rst_time", time_o[0], 0);
    chk("rst_best", best_o[0], 0);
    chk("rst_led", led_o[0], 0);
    chk("rst_dly_en", en_o[0], 0);
    iRST = 0;
    tick();

    // normal rounds and best tracking: 5, 3, 8 ms
    play(57);
    chk("r1_time", time_o[0], 5);
    chk("r1_valid", valid_o[0], 1);
    chk("r1_best", best_o[0], 5);
    chk("r1_led_off", led_o[0], 0);
    chk("r1_b_timeout", tout_o[1], 1);
    chk("r1_b_time", time_o[1], 4);
    chk("r1_b_best", best_o[1], 0);
    tick();
    chk("r1_valid_single", valid_o[0], 0);
    play(37);
    chk("r2_time", time_o[0], 3);
    chk("r2_best", best_o[0], 3);
    chk("r2_b_valid", valid_o[1], 1);
    chk("r2_b_time", time_o[1], 3);
    play(85);
    chk("r3_time", time_o[0], 8);
    chk("r3_best", best_o[0], 3);

    // false start in WAIT, early restart ignored, restart after the drain
    iSTART = 1;
    tick();
    tick();
    tick();
    iPRESS = 1;
    tick();
    chk("foul_flag", foul_o[0], 1);
    chk("foul_led", led_o[0], 0);
    iSTART = 1;
    tick();
    chk("foul_start_ignored", en_o[0], 0);
    wait_done(0);
    tick();
    chk("foul_led_after_done", led_o[0], 0);
    chk("foul_time_kept", time_o[0], 8);
    iSTART = 1;
    tick();
    chk("foul_rearm", en_o[0], 1);
    chk("foul_cleared", foul_o[0], 0);
    tick();
    wait_led(0);
    repeat (49) tick();
    iPRESS = 1;
    tick();
    chk("r4_time", time_o[0], 4);

    // press collides with the done pulse
    iSTART = 1;
    tick();
    wait_done(0);
    iPRESS = 1;
    tick();
    chk("collide_foul", foul_o[0], 1);
    chk("collide_led", led_o[0], 0);
    repeat (5) tick();
    chk("collide_led_later", led_o[0], 0);

    // press on the exact timeout wrap, then a full timeout
    play(39);
    chk("wrap_b_time", time_o[1], 3);
    chk("wrap_b_valid", valid_o[1], 1);
    chk("wrap_b_timeout", tout_o[1], 0);
    iSTART = 1;
    tick();
    tick();
    wait_led(1);
    repeat (39) tick();
    chk("to_b_led_before", led_o[1], 1);
    tick();
    chk("to_b_timeout", tout_o[1], 1);
    chk("to_b_time", time_o[1], 4);
    chk("to_b_valid", valid_o[1], 0);
    chk("to_b_best", best_o[1], 3);
    chk("to_b_led_off", led_o[1], 0);
    repeat (5) tick();
    iPRESS = 1;
    tick();
    chk("to_a_time", time_o[0], 4);
    chk("to_b_press_ignored", valid_o[1], 0);

    // reset in the middle of GO
    iSTART = 1;
    tick();
    wait_led(0);
    repeat (10) tick();
    iRST = 1;
    tick();
    chk("midrst_led", led_o[0], 0);
    chk("midrst_time", time_o[0], 0);
    chk("midrst_best", best_o[0], 0);
    chk("midrst_valid", valid_o[0], 0);
    iRST = 0;
    tick();
    iSTART = 1;
    tick();
    chk("midrst_rearm", en_o[0], 1);

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      iSTART  = ($urandom_range(0, 39) == 0);
      iPRESS  = ($urandom_range(0, 29) == 0);
      iRST    = ($urandom_range(0, 1999) == 0);
      dly_len = $urandom_range(1, 25);
      tick();
    end
    iRST = 0;
    tick();
    @(negedge iCLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
